// File: rtl/control_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : control_unit_pipe
// Purpose  : RV32I decode with a registered D->E control bundle (stall/flush);
//            optional multi-cycle MUL/DIV hold enabled by CONTROL_UNIT_MEXT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module control_unit_pipe #(
  parameter int ALUCTRL_W = 4,
  parameter int MUL_LAT   = 3,
  parameter int DIV_LAT   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           Opcode,
  input  logic [2:0]           fun3,
  input  logic [6:0]           fun7,
  input  logic                 stall_E,
  input  logic                 flush_E,
  output logic [2:0]           ImmSrc_D,
  output logic                 busy_D,
  output logic                 RegWrite_E,
  output logic [1:0]           ResultSrc_E,
  output logic                 MemWrite_E,
  output logic                 Jump_E,
  output logic                 JumpReg_E,
  output logic                 Branch_E,
  output logic                 ALUSrc_E,
  output logic                 ALUSrcA_E,
  output logic [ALUCTRL_W-1:0] ALUControl_E,
  output logic                 illegal_E
);
  localparam logic [6:0] c_op_r     = 7'b0110011;
  localparam logic [6:0] c_op_i     = 7'b0010011;
  localparam logic [6:0] c_op_ld    = 7'b0000011;
  localparam logic [6:0] c_op_st    = 7'b0100011;
  localparam logic [6:0] c_op_br    = 7'b1100011;
  localparam logic [6:0] c_op_jal   = 7'b1101111;
  localparam logic [6:0] c_op_jalr  = 7'b1100111;
  localparam logic [6:0] c_op_lui   = 7'b0110111;
  localparam logic [6:0] c_op_auipc = 7'b0010111;

  localparam logic [3:0] c_add  = 4'h0;
  localparam logic [3:0] c_sub  = 4'h1;
  localparam logic [3:0] c_and  = 4'h2;
  localparam logic [3:0] c_or   = 4'h3;
  localparam logic [3:0] c_xor  = 4'h4;
  localparam logic [3:0] c_slt  = 4'h5;
  localparam logic [3:0] c_sll  = 4'h6;
  localparam logic [3:0] c_srl  = 4'h7;
  localparam logic [3:0] c_sge  = 4'h8;
  localparam logic [3:0] c_neq  = 4'hA;
  localparam logic [3:0] c_sltu = 4'hB;
  localparam logic [3:0] c_sgeu = 4'hC;
  localparam logic [3:0] c_sra  = 4'hD;
`ifdef CONTROL_UNIT_MEXT_EN
  localparam logic [3:0] c_mul  = 4'hE;
  localparam logic [3:0] c_div  = 4'hF;
`endif

  logic       w_rw, w_mw, w_j, w_jr, w_br, w_as, w_asa, w_ill;
  logic [1:0] w_rs;
  logic [3:0] w_alu, w_base_alu;
  logic [2:0] w_imm;
  logic [13:0] w_ctl;
  logic [13:0] r_ctl;

  always_comb begin
    case (fun3)
      3'b000:  w_base_alu = c_add;
      3'b001:  w_base_alu = c_sll;
      3'b010:  w_base_alu = c_slt;
      3'b011:  w_base_alu = c_sltu;
      3'b100:  w_base_alu = c_xor;
      3'b101:  w_base_alu = c_srl;
      3'b110:  w_base_alu = c_or;
      default: w_base_alu = c_and;
    endcase
  end

  always_comb begin
    w_rw  = 1'b0;
    w_rs  = 2'b00;
    w_mw  = 1'b0;
    w_j   = 1'b0;
    w_jr  = 1'b0;
    w_br  = 1'b0;
    w_as  = 1'b0;
    w_asa = 1'b0;
    w_ill = 1'b0;
    w_alu = c_add;
    w_imm = 3'b000;
    case (Opcode)
      c_op_r: begin
        w_rw = 1'b1;
        if (fun7 == 7'b0000000)                         w_alu = w_base_alu;
        else if (fun7 == 7'b0100000 && fun3 == 3'b000)  w_alu = c_sub;
        else if (fun7 == 7'b0100000 && fun3 == 3'b101)  w_alu = c_sra;
`ifdef CONTROL_UNIT_MEXT_EN
        else if (fun7 == 7'b0000001)                    w_alu = fun3[2] ? c_div : c_mul;
`endif
        else                                            w_ill = 1'b1;
      end
      c_op_i: begin
        w_rw  = 1'b1;
        w_as  = 1'b1;
        w_alu = (fun3 == 3'b101 && fun7[5]) ? c_sra : w_base_alu;
        if ((fun3 == 3'b001 || fun3 == 3'b101) && fun7 != 7'b0000000 && fun7 != 7'b0100000)
          w_ill = 1'b1;
      end
      c_op_ld: begin
        w_rw = 1'b1;
        w_as = 1'b1;
        w_rs = 2'b01;
      end
      c_op_st: begin
        w_mw  = 1'b1;
        w_as  = 1'b1;
        w_imm = 3'b001;
      end
      c_op_br: begin
        w_br  = 1'b1;
        w_imm = 3'b010;
        case (fun3)
          3'b000:  w_alu = c_sub;
          3'b001:  w_alu = c_neq;
          3'b100:  w_alu = c_slt;
          3'b101:  w_alu = c_sge;
          3'b110:  w_alu = c_sltu;
          3'b111:  w_alu = c_sgeu;
          default: w_ill = 1'b1;
        endcase
      end
      c_op_jal: begin
        w_rw  = 1'b1;
        w_j   = 1'b1;
        w_rs  = 2'b10;
        w_imm = 3'b011;
      end
      c_op_jalr: begin
        w_rw = 1'b1;
        w_j  = 1'b1;
        w_jr = 1'b1;
        w_as = 1'b1;
        w_rs = 2'b10;
      end
      c_op_lui: begin
        w_rw  = 1'b1;
        w_rs  = 2'b11;
        w_imm = 3'b100;
      end
      c_op_auipc: begin
        w_rw  = 1'b1;
        w_asa = 1'b1;
        w_as  = 1'b1;
        w_imm = 3'b100;
      end
      default: w_ill = 1'b1;
    endcase
  end

  assign ImmSrc_D = w_imm;
  // An illegal instruction becomes a bubble that only carries the flag.
  assign w_ctl = w_ill ? 14'h0001
                       : {w_rw, w_rs, w_mw, w_j, w_jr, w_br, w_as, w_asa, w_alu, 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_ctl <= '0;
    else if (flush_E)
      r_ctl <= '0;
    else if (!(stall_E || busy_D))
      r_ctl <= w_ctl;
  end

  assign {RegWrite_E, ResultSrc_E, MemWrite_E, Jump_E, JumpReg_E,
          Branch_E, ALUSrc_E, ALUSrcA_E} = r_ctl[13:5];
  assign ALUControl_E = ALUCTRL_W'(r_ctl[4:1]);
  assign illegal_E    = r_ctl[0];

`ifdef CONTROL_UNIT_MEXT_EN
  localparam int c_max_lat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int c_cnt_w   = $clog2(c_max_lat + 1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;
  state_t             r_state, w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt, w_lat_m1;
  logic               w_mop;

  assign w_mop    = !w_ill && (w_alu == c_mul || w_alu == c_div);
  assign w_lat_m1 = (w_alu == c_mul) ? c_cnt_w'(MUL_LAT - 1) : c_cnt_w'(DIV_LAT - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The counter keeps running under stall_E so an M op never overstays LAT cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (flush_E) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!stall_E && w_mop) begin
            w_cnt_nxt   = w_lat_m1;
            w_state_nxt = (w_lat_m1 != '0) ? S_BUSY : S_IDLE;
          end
        end
        S_BUSY: begin
          w_cnt_nxt = r_cnt - c_cnt_w'(1);
          if (r_cnt == c_cnt_w'(1))
            w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign busy_D = (r_cnt != '0);
`else
  logic w_unused_lat;
  assign w_unused_lat = (MUL_LAT + DIV_LAT) > 0;
  assign busy_D       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_control_unit_pipe.sv
`default_nettype none
// Testbench for control_unit_pipe: directed vector table, hand sequences for
// stall/flush/reset/M-extension, then random stimulus against a decode model.
module tb_control_unit_pipe;
  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 8;
`ifdef CONTROL_UNIT_MEXT_EN
  localparam bit MEXT = 1'b1;
`else
  localparam bit MEXT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] Opcode, fun7;
  logic [2:0] fun3;
  logic       stall_E, flush_E;
  logic [2:0] ImmSrc_D;
  logic       busy_D, RegWrite_E, MemWrite_E, Jump_E, JumpReg_E, Branch_E;
  logic       ALUSrc_E, ALUSrcA_E, illegal_E;
  logic [1:0] ResultSrc_E;
  logic [3:0] ALUControl_E;

  always #5 clk = ~clk;

  control_unit_pipe #(.ALUCTRL_W(4), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst(rst), .Opcode(Opcode), .fun3(fun3), .fun7(fun7),
    .stall_E(stall_E), .flush_E(flush_E), .ImmSrc_D(ImmSrc_D), .busy_D(busy_D),
    .RegWrite_E(RegWrite_E), .ResultSrc_E(ResultSrc_E), .MemWrite_E(MemWrite_E),
    .Jump_E(Jump_E), .JumpReg_E(JumpReg_E), .Branch_E(Branch_E),
    .ALUSrc_E(ALUSrc_E), .ALUSrcA_E(ALUSrcA_E), .ALUControl_E(ALUControl_E),
    .illegal_E(illegal_E)
  );

  typedef struct packed {
    logic       rw;
    logic [1:0] rs;
    logic       mw, j, jr, br, as, asa;
    logic [3:0] alu;
    logic       ill;
  } ctl_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [2:0] imm;
    ctl_t       ctl;
  } vec_t;

  ctl_t w_act;
  assign w_act = {RegWrite_E, ResultSrc_E, MemWrite_E, Jump_E, JumpReg_E,
                  Branch_E, ALUSrc_E, ALUSrcA_E, ALUControl_E, illegal_E};

  int   total = 0;
  int   bad   = 0;
  ctl_t m_e;
  int   m_hold;
  logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, a, e);
    end
  endtask

  function automatic ctl_t mk(input bit rw, input bit [1:0] rs, input bit mw, input bit j,
                              input bit jr, input bit br, input bit as, input bit asa,
                              input bit [3:0] alu);
    ctl_t c;
    c.rw = rw; c.rs = rs; c.mw = mw; c.j = j; c.jr = jr; c.br = br;
    c.as = as; c.asa = asa; c.alu = alu; c.ill = 1'b0;
    return c;
  endfunction

  // Reference decode: lookup nibble tables indexed by fun3, rules straight from the ISA description.
  function automatic ctl_t ref_decode(input logic [6:0] op, input logic [2:0] f3,
                                      input logic [6:0] f7, output logic [2:0] imm);
    ctl_t        c;
    bit          illg;
    logic [31:0] rt, bt;
    rt = 32'h2374B560;
    bt = 32'hCB8500A1;
    c = '0; illg = 1'b0; imm = 3'd0;
    case (op)
      7'h33: begin
        c.rw = 1'b1;
        if (f7 == 7'h00) c.alu = rt[int'(f3)*4 +: 4];
        else if (f7 == 7'h20 && f3 == 3'd0) c.alu = 4'h1;
        else if (f7 == 7'h20 && f3 == 3'd5) c.alu = 4'hD;
        else if (MEXT && f7 == 7'h01) c.alu = f3[2] ? 4'hF : 4'hE;
        else illg = 1'b1;
      end
      7'h13: begin
        c.rw = 1'b1; c.as = 1'b1;
        c.alu = (f3 == 3'd5 && f7[5]) ? 4'hD : rt[int'(f3)*4 +: 4];
        if ((f3 == 3'd1 || f3 == 3'd5) && f7 != 7'h00 && f7 != 7'h20) illg = 1'b1;
      end
      7'h03: begin c.rw = 1'b1; c.as = 1'b1; c.rs = 2'b01; end
      7'h23: begin c.mw = 1'b1; c.as = 1'b1; imm = 3'd1; end
      7'h63: begin
        c.br = 1'b1; imm = 3'd2;
        if (f3 == 3'd2 || f3 == 3'd3) illg = 1'b1;
        else c.alu = bt[int'(f3)*4 +: 4];
      end
      7'h6F: begin c.rw = 1'b1; c.j = 1'b1; c.rs = 2'b10; imm = 3'd3; end
      7'h67: begin c.rw = 1'b1; c.j = 1'b1; c.jr = 1'b1; c.as = 1'b1; c.rs = 2'b10; end
      7'h37: begin c.rw = 1'b1; c.rs = 2'b11; imm = 3'd4; end
      7'h17: begin c.rw = 1'b1; c.asa = 1'b1; c.as = 1'b1; imm = 3'd4; end
      default: illg = 1'b1;
    endcase
    if (illg) begin
      c = '0;
      c.ill = 1'b1;
    end
    return c;
  endfunction

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic st, input logic fl);
    Opcode = op; fun3 = f3; fun7 = f7; stall_E = st; flush_E = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t       vt [16];
    ctl_t       c_ill, c_add, c_mul, c_div, exp_c;
    logic [2:0] ei;

    c_ill = '0; c_ill.ill = 1'b1;
    c_add = mk(1, 2'b00, 0, 0, 0, 0, 0, 0, 4'h0);
    c_mul = mk(1, 2'b00, 0, 0, 0, 0, 0, 0, 4'hE);
    c_div = mk(1, 2'b00, 0, 0, 0, 0, 0, 0, 4'hF);

    vt[0]  = '{7'h33, 3'd0, 7'h00, 3'd0, c_add};
    vt[1]  = '{7'h33, 3'd0, 7'h20, 3'd0, mk(1, 2'b00, 0, 0, 0, 0, 0, 0, 4'h1)};
    vt[2]  = '{7'h33, 3'd5, 7'h20, 3'd0, mk(1, 2'b00, 0, 0, 0, 0, 0, 0, 4'hD)};
    vt[3]  = '{7'h03, 3'd2, 7'h00, 3'd0, mk(1, 2'b01, 0, 0, 0, 0, 1, 0, 4'h0)};
    vt[4]  = '{7'h63, 3'd7, 7'h00, 3'd2, mk(0, 2'b00, 0, 0, 0, 1, 0, 0, 4'hC)};
    vt[5]  = '{7'h7F, 3'd0, 7'h00, 3'd0, c_ill};
    vt[6]  = '{7'h63, 3'd2, 7'h00, 3'd2, c_ill};
    vt[7]  = '{7'h23, 3'd2, 7'h00, 3'd1, mk(0, 2'b00, 1, 0, 0, 0, 1, 0, 4'h0)};
    vt[8]  = '{7'h6F, 3'd0, 7'h00, 3'd3, mk(1, 2'b10, 0, 1, 0, 0, 0, 0, 4'h0)};
    vt[9]  = '{7'h67, 3'd0, 7'h00, 3'd0, mk(1, 2'b10, 0, 1, 1, 0, 1, 0, 4'h0)};
    vt[10] = '{7'h37, 3'd0, 7'h00, 3'd4, mk(1, 2'b11, 0, 0, 0, 0, 0, 0, 4'h0)};
    vt[11] = '{7'h17, 3'd0, 7'h00, 3'd4, mk(1, 2'b00, 0, 0, 0, 0, 1, 1, 4'h0)};
    vt[12] = '{7'h13, 3'd5, 7'h20, 3'd0, mk(1, 2'b00, 0, 0, 0, 0, 1, 0, 4'hD)};
    vt[13] = '{7'h33, 3'd1, 7'h20, 3'd0, c_ill};
    vt[14] = '{7'h13, 3'd1, 7'h01, 3'd0, c_ill};
    vt[15] = '{7'h63, 3'd1, 7'h00, 3'd2, mk(0, 2'b00, 0, 0, 0, 1, 0, 0, 4'hA)};

    rst = 1'b1;
    Opcode = 7'h00; fun3 = 3'd0; fun7 = 7'h00; stall_E = 1'b0; flush_E = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctl", 32'(w_act), 32'd0);
    chk("reset_busy", 32'(busy_D), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    foreach (vt[i]) begin
      drive(vt[i].op, vt[i].f3, vt[i].f7, 1'b0, 1'b0);
      chk($sformatf("vec%0d_imm", i), 32'(ImmSrc_D), 32'(vt[i].imm));
      tick();
      chk($sformatf("vec%0d_ctl", i), 32'(w_act), 32'(vt[i].ctl));
    end

    drive(7'h33, 3'd0, 7'h00, 1'b0, 1'b0);
    tick();
    chk("stall_load", 32'(w_act), 32'(c_add));
    drive(7'h33, 3'd0, 7'h20, 1'b1, 1'b0);
    tick();
    chk("stall_hold1", 32'(w_act), 32'(c_add));
    tick();
    chk("stall_hold2", 32'(w_act), 32'(c_add));
    drive(7'h33, 3'd0, 7'h20, 1'b1, 1'b1);
    tick();
    chk("stall_flush", 32'(w_act), 32'd0);

    if (MEXT) begin
      drive(7'h33, 3'd0, 7'h01, 1'b0, 1'b0);
      tick();
      chk("mul_c1", 32'(w_act), 32'(c_mul));
      chk("mul_busy1", 32'(busy_D), 32'd1);
      drive(7'h33, 3'd0, 7'h00, 1'b0, 1'b0);
      tick();
      chk("mul_c2", 32'(w_act), 32'(c_mul));
      chk("mul_busy2", 32'(busy_D), 32'd1);
      tick();
      chk("mul_c3", 32'(w_act), 32'(c_mul));
      chk("mul_busy3", 32'(busy_D), 32'd0);
      tick();
      chk("mul_next", 32'(w_act), 32'(c_add));
      drive(7'h33, 3'd4, 7'h01, 1'b0, 1'b0);
      tick();
      chk("div_c1", 32'(w_act), 32'(c_div));
      chk("div_busy1", 32'(busy_D), 32'd1);
      drive(7'h33, 3'd0, 7'h00, 1'b0, 1'b1);
      tick();
      chk("div_flush", 32'(w_act), 32'd0);
      chk("div_flush_busy", 32'(busy_D), 32'd0);
    end else begin
      drive(7'h33, 3'd0, 7'h01, 1'b0, 1'b0);
      tick();
      chk("mul_illegal", 32'(w_act), 32'(c_ill));
      chk("mul_nobusy", 32'(busy_D), 32'd0);
    end

    drive(7'h33, 3'd0, 7'h01, 1'b0, 1'b0);
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_ctl", 32'(w_act), 32'd0);
    chk("async_rst_busy", 32'(busy_D), 32'd0);
    @(negedge clk);
    flush_E = 1'b1;
    rst = 1'b0;
    tick();
    m_e = '0;
    m_hold = 0;

    for (int n = 0; n < 500; n++) begin
      logic [6:0] op, f7;
      logic [2:0] f3;
      logic       st, fl;
      int         pick;
      pick = $urandom_range(0, 9);
      op = (pick == 9) ? 7'($urandom) : ops[pick];
      f3 = 3'($urandom);
      case ($urandom_range(0, 3))
        0:       f7 = 7'h00;
        1:       f7 = 7'h20;
        2:       f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      st = ($urandom_range(0, 4) == 0);
      fl = ($urandom_range(0, 9) == 0);
      drive(op, f3, f7, st, fl);
      exp_c = ref_decode(op, f3, f7, ei);
      chk("rnd_imm", 32'(ImmSrc_D), 32'(ei));
      chk("rnd_busy", 32'(busy_D), 32'(m_hold > 0));
      @(posedge clk);
      if (fl) begin
        m_e = '0;
        m_hold = 0;
      end else if (st || m_hold > 0) begin
        if (m_hold > 0) m_hold--;
      end else begin
        m_e = exp_c;
        if (!exp_c.ill && (exp_c.alu == 4'hE || exp_c.alu == 4'hF))
          m_hold = ((exp_c.alu == 4'hE) ? MUL_LAT : DIV_LAT) - 1;
      end
      #1;
      chk("rnd_ctl", 32'(w_act), 32'(m_e));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
